// File: rtl/logic_unit_fifo.sv
// logic_unit_fifo: bitwise logic unit with an optional accumulate path and a result FIFO.
//
// Each accepted operand set (in_valid && in_ready) produces one result, which is
// written to the FIFO tail on the same edge. The FIFO head appears on out/out_valid.
// Consumers pop it with out_ready.
//
// Parameters
//   WIDTH  operand/result width, 1..64
//   DEPTH  result FIFO entries, power of two, 2..16
// Ports
//   clk        clock; every state update happens on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand set on in1/in2/op/acc is valid
//   in_ready   FIFO has room; driven from registered state only
//   op         000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 NOT A, 111 pass A
//   acc        operand A is the previous result instead of in1
//   in1, in2   operands A and B
//   out_valid  out holds a valid result
//   out_ready  consumer takes the head result
//   out        result at the FIFO head (0 when empty)
// Optional feature (macro LOGIC_UNIT_FLAGS_EN)
//   zero       head result == 0
//   parity     XOR-reduce of the head result
module logic_unit_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output logic [WIDTH-1:0] out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             zero_q   [DEPTH];
  logic             parity_q [DEPTH];
`endif
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] last_q;

  logic [WIDTH-1:0] opa, result;
  logic             push, pop;

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out = out_valid ? mem_q[rd_ptr_q] : '0;
`ifdef LOGIC_UNIT_FLAGS_EN
  assign zero   = out_valid ? zero_q[rd_ptr_q]   : 1'b0;
  assign parity = out_valid ? parity_q[rd_ptr_q] : 1'b0;
`endif

  // Accumulate replaces operand A with the most recent accepted result.
  assign opa = acc ? last_q : in1;

  always_comb begin
    result = '0;
    unique case (op)
      3'b000:  result = opa & in2;
      3'b001:  result = opa | in2;
      3'b010:  result = opa ^ in2;
      3'b011:  result = ~(opa | in2);
      3'b100:  result = ~(opa & in2);
      3'b101:  result = ~(opa ^ in2);
      3'b110:  result = ~opa;
      default: result = opa;
    endcase
  end

  // Occupancy only moves when exactly one of push/pop happens; both together keep it.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef LOGIC_UNIT_FLAGS_EN
        zero_q[i]   <= 1'b0;
        parity_q[i] <= 1'b0;
`endif
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= result;
`ifdef LOGIC_UNIT_FLAGS_EN
        zero_q[wr_ptr_q]   <= (result == '0);
        parity_q[wr_ptr_q] <= ^result;
`endif
        // DEPTH is a power of two, so the pointer wraps naturally.
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        last_q   <= result;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_fifo.sv
module tb_logic_unit_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       acc;
  logic [7:0] in1, in2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic       zero, parity;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] op_exp [8];
  logic [7:0] seq_exp [12];

  logic_unit_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc       (acc),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero      (zero),
    .parity    (parity),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    op_exp[0] = 8'h05; op_exp[1] = 8'hAF; op_exp[2] = 8'hAA; op_exp[3] = 8'h50;
    op_exp[4] = 8'hFA; op_exp[5] = 8'h55; op_exp[6] = 8'h5A; op_exp[7] = 8'hA5;
    seq_exp[0] = 8'h20;
    seq_exp[1] = 8'h21;
    for (int j = 2; j < 12; j++) seq_exp[j] = 8'(8'h30 + j - 2);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; acc = 1'b0; in1 = 8'h00; in2 = 8'h00;
    #12;
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out", 64'(out), 64'd0);

    // All eight ops on A5/0F, streaming with out_ready held high.
    out_ready = 1'b1; in_valid = 1'b1; in1 = 8'hA5; in2 = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
      chk($sformatf("op%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("op%0d_out", i), 64'(out), 64'(op_exp[i]));
    end
    in_valid = 1'b0;
    step();
    chk("ops_drained", 64'(out_valid), 64'd0);

    // Accumulate chain.
    in_valid = 1'b1; op = 3'b001;
    acc = 1'b0; in1 = 8'h01; in2 = 8'h00;
    step();
    chk("acc_0", 64'(out), 64'h01);
    acc = 1'b1; in1 = 8'hEE; in2 = 8'h02;
    step();
    chk("acc_1", 64'(out), 64'h03);
    in2 = 8'h80;
    step();
    chk("acc_2", 64'(out), 64'h83);
    in_valid = 1'b0; acc = 1'b0;
    step();
    chk("acc_drained", 64'(out_valid), 64'd0);

    // Fill to full with the consumer stalled.
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b111;
    for (int i = 0; i < 6; i++) begin
      in1 = 8'(8'h10 + i);
      step();
      chk($sformatf("fill%0d_in_ready", i), 64'(in_ready), (i < 3) ? 64'd1 : 64'd0);
      chk($sformatf("fill%0d_out_stable", i), 64'(out), 64'h10);
      chk($sformatf("fill%0d_valid", i), 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), 64'(out), 64'(8'h10 + k));
      step();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);

    // Two queued, then simultaneous push/pop for 10 cycles across pointer wrap.
    out_ready = 1'b0; in_valid = 1'b1;
    in1 = 8'h20; step();
    in1 = 8'h21; step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stream%0d_out", i), 64'(out), 64'(seq_exp[i]));
      chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
      in1 = 8'(8'h30 + i);
      step();
    end
    in_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      chk($sformatf("stream%0d_out", i), 64'(out), 64'(seq_exp[i]));
      step();
    end
    chk("stream_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset with three queued results.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1 = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_out", 64'(out), 64'h40);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    chk("async_rst_out", 64'(out), 64'd0);
    #2;
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; acc = 1'b1; op = 3'b001; in1 = 8'hFF; in2 = 8'h3C;
    step();
    chk("post_rst_acc_valid", 64'(out_valid), 64'd1);
    chk("post_rst_acc_out", 64'(out), 64'h3C);
    acc = 1'b0;

`ifdef LOGIC_UNIT_FLAGS_EN
    in1 = 8'hFF; in2 = 8'hFF; op = 3'b010;
    step();
    chk("flags_xor_out", 64'(out), 64'h00);
    chk("flags_xor_zero", 64'(zero), 64'd1);
    chk("flags_xor_parity", 64'(parity), 64'd0);
    in1 = 8'h07; op = 3'b111;
    step();
    chk("flags_pass_out", 64'(out), 64'h07);
    chk("flags_pass_zero", 64'(zero), 64'd0);
    chk("flags_pass_parity", 64'(parity), 64'd1);
`endif

    in_valid = 1'b0;
    step();
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
